// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD controller Wishbone arbiter slice.
package sdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WAIT_CNT_W      = 16;

  // Counter value at which the forced error fires (counter starts at 0 on the first strobe cycle).
  function automatic logic [WAIT_CNT_W-1:0] timeout_limit(input int unsigned timeout);
    return WAIT_CNT_W'(timeout - 32'd1);
  endfunction

endpackage

// File: rtl/sdc_wb_timeout.sv
// Slave wait counter: counts strobe cycles without ack and flags the cycle that must be errored.
module sdc_wb_timeout
  import sdc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_timeout
);

  localparam logic [WAIT_CNT_W-1:0] LP_LIMIT = timeout_limit(TIMEOUT);

  logic [WAIT_CNT_W-1:0] r_cnt;
  logic                  w_expired;

  // An ack in the limit cycle wins, so the expiry term requires ack low.
  assign w_expired = i_stb && !i_ack && (r_cnt == LP_LIMIT);
  assign o_timeout = w_expired;

  // Wait counter: restarts on idle strobe, ack, or the forced-error cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt <= '0;
    end else if (!i_stb || i_ack || w_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sdc_wb_arbiter.sv
// Two-requester classic Wishbone arbiter in front of the SD controller register port,
// with round-robin tie break and a slave-ack timeout that errors the granted requester.
module sdc_wb_arbiter
  import sdc_pkg::*;
#(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [AW-1:0]     m0_adr,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DW-1:0]     m0_dat_o,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [AW-1:0]     m1_adr,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DW-1:0]     m1_dat_o,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [AW-1:0]     s_adr,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel,
  input  logic              s_ack,
  input  logic [DW-1:0]     s_dat_i
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_last_m1;
  logic       w_last_m1_nxt;
  logic       r_lock0;
  logic       r_lock1;
  logic       w_lock0_nxt;
  logic       w_lock1_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_gnt_stb;
  logic       w_timeout;

  // A requester that was timed out must drop cyc before it may compete again.
  assign w_req0 = m0_cyc && !r_lock0;
  assign w_req1 = m1_cyc && !r_lock1;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Raw strobe of the granted requester, before any timeout masking.
  always_comb begin
    w_gnt_stb = 1'b0;
    case (r_state)
      GNT0:    w_gnt_stb = m0_stb;
      GNT1:    w_gnt_stb = m1_stb;
      default: w_gnt_stb = 1'b0;
    endcase
  end

  sdc_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_stb     (w_gnt_stb),
    .i_ack     (s_ack),
    .o_timeout (w_timeout)
  );

  // Arbitration state, last-granted pointer and timeout lockout flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_last_m1 <= 1'b1;
      r_lock0   <= 1'b0;
      r_lock1   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last_m1 <= w_last_m1_nxt;
      r_lock0   <= w_lock0_nxt;
      r_lock1   <= w_lock1_nxt;
    end
  end

  // Next-state: grants only from IDLE, so every hand-over passes through one dead cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_m1_nxt = r_last_m1;
    w_lock0_nxt   = m0_cyc ? r_lock0 : 1'b0;
    w_lock1_nxt   = m1_cyc ? r_lock1 : 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          if (r_last_m1) begin
            w_state_nxt   = GNT0;
            w_last_m1_nxt = 1'b0;
          end else begin
            w_state_nxt   = GNT1;
            w_last_m1_nxt = 1'b1;
          end
        end else if (w_req0) begin
          w_state_nxt   = GNT0;
          w_last_m1_nxt = 1'b0;
        end else if (w_req1) begin
          w_state_nxt   = GNT1;
          w_last_m1_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT0: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
          w_lock0_nxt = 1'b1;
        end else if (!m0_cyc) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GNT0;
        end
      end
      GNT1: begin
        if (w_timeout) begin
          w_state_nxt = IDLE;
          w_lock1_nxt = 1'b1;
        end else if (!m1_cyc) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GNT1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Zero-cycle forwarding of the granted requester; the timeout cycle masks cyc/stb.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    s_sel   = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    case (r_state)
      GNT0: begin
        s_cyc   = m0_cyc && !w_timeout;
        s_stb   = m0_stb && !w_timeout;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_o = m0_dat_i;
        s_sel   = m0_sel;
        m0_ack  = s_ack;
        m0_err  = w_timeout;
      end
      GNT1: begin
        s_cyc   = m1_cyc && !w_timeout;
        s_stb   = m1_stb && !w_timeout;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_o = m1_dat_i;
        s_sel   = m1_sel;
        m1_ack  = s_ack;
        m1_err  = w_timeout;
      end
      default: begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdc_wb_arbiter.sv
// Scoreboard bench for sdc_wb_arbiter: expected responses queued at stimulus, popped on ack/err.
module tb_sdc_wb_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          aclk;
  logic          aresetn;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_i;
  logic [SW-1:0] m0_sel;
  logic          m0_ack, m0_err;
  logic [DW-1:0] m0_dat_o;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_i;
  logic [SW-1:0] m1_sel;
  logic          m1_ack, m1_err;
  logic [DW-1:0] m1_dat_o;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel;
  logic          s_ack;
  logic [DW-1:0] s_dat_i;

  int checks;
  int errors;

  typedef struct {
    logic          master;
    logic          is_err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;

  sdc_wb_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_adr   (m0_adr),
    .m0_dat_i (m0_dat_i),
    .m0_sel   (m0_sel),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_dat_o (m0_dat_o),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_adr   (m1_adr),
    .m1_dat_i (m1_dat_i),
    .m1_sel   (m1_sel),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .m1_dat_o (m1_dat_o),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_o  (s_dat_o),
    .s_sel    (s_sel),
    .s_ack    (s_ack),
    .s_dat_i  (s_dat_i)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // {m1_err, m1_ack, m0_err, m0_ack}
  function automatic logic [3:0] exp_resp(input exp_t x);
    return {x.master & x.is_err, x.master & ~x.is_err, ~x.master & x.is_err, ~x.master & ~x.is_err};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat_i = '0; m0_sel = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat_i = '0; m1_sel = '0;
    s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic m_req(input int m, input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we);
    if (m == 0) begin
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr; m0_dat_i = dat; m0_sel = 4'hF;
    end else begin
      m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr; m1_dat_i = dat; m1_sel = 4'hF;
    end
  endtask

  task automatic m_drop(input int m);
    if (m == 0) begin
      m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    end else begin
      m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err} !== 6'b000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000", {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err});
    end
    idle_inputs();
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: s_cyc got %b want 0", s_cyc);
    end
  endtask

  task automatic test_single_write();
    tick();
    m_req(0, 30'h0A, 32'hDEADBEEF, 1'b1);
    sb_q.push_back('{master: 1'b0, is_err: 1'b0, dat: 32'h1234_5678});
    @(negedge aclk);
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL grant_latency: s_cyc got %b want 0 before grant edge", s_cyc);
    end
    tick();
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel} !== {1'b1, 1'b1, 1'b1, 30'h0A, 32'hDEADBEEF, 4'hF}) begin
      errors++;
      $display("FAIL fwd_m0: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want 1 1 1 0a deadbeef f",
               s_cyc, s_stb, s_we, s_adr, s_dat_o, s_sel);
    end
    tick();
    tick();
    s_ack = 1'b1; s_dat_i = 32'h1234_5678;
    @(negedge aclk);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL single_resp: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e) || m0_dat_o !== e.dat || m1_dat_o !== e.dat) begin
        errors++;
        $display("FAIL single_resp: resp got %b want %b, dat0 %h dat1 %h want %h",
                 {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e), m0_dat_o, m1_dat_o, e.dat);
      end
    end
    tick();
    s_ack = 1'b0; s_dat_i = '0;
    m_drop(0);
    @(negedge aclk);
    checks++;
    if ({m0_ack, m1_ack} !== 2'b00) begin
      errors++;
      $display("FAIL single_ack_width: acks got %b want 00", {m0_ack, m1_ack});
    end
    tick();
  endtask

  task automatic test_tie_round_robin();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    m_req(0, 30'h11, 32'h0000_0011, 1'b0);
    m_req(1, 30'h22, 32'h0000_0022, 1'b1);
    tick();
    s_ack = 1'b1; s_dat_i = 32'hA5A5_0000;
    sb_q.push_back('{master: 1'b0, is_err: 1'b0, dat: 32'hA5A5_0000});
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_we, s_adr} !== {1'b1, 1'b0, 30'h11}) begin
      errors++;
      $display("FAIL tie_m0_first: got cyc=%b we=%b adr=%h want 1 0 11", s_cyc, s_we, s_adr);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL tie_resp_m0: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e) || m0_dat_o !== e.dat) begin
        errors++;
        $display("FAIL tie_resp_m0: resp got %b want %b dat %h want %h",
                 {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e), m0_dat_o, e.dat);
      end
    end
    tick();
    s_ack = 1'b0;
    m_drop(0);
    @(negedge aclk);
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL drop_cycle: s_cyc got %b want 0", s_cyc);
    end
    tick();
    @(negedge aclk);
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL dead_cycle: s_cyc got %b want 0 in idle", s_cyc);
    end
    tick();
    s_ack = 1'b1; s_dat_i = 32'h5A5A_0001;
    sb_q.push_back('{master: 1'b1, is_err: 1'b0, dat: 32'h5A5A_0001});
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_we, s_adr, s_dat_o} !== {1'b1, 1'b1, 30'h22, 32'h0000_0022}) begin
      errors++;
      $display("FAIL gnt1_after_idle: got cyc=%b we=%b adr=%h dat=%h want 1 1 22 00000022",
               s_cyc, s_we, s_adr, s_dat_o);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL tie_resp_m1: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e) || m1_dat_o !== e.dat) begin
        errors++;
        $display("FAIL tie_resp_m1: resp got %b want %b dat %h want %h",
                 {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e), m1_dat_o, e.dat);
      end
    end
    tick();
    s_ack = 1'b0; s_dat_i = '0;
    m_drop(1);
    tick();
  endtask

  task automatic test_timeout();
    logic got;
    int   n;
    logic stb_at, cyc_at;
    logic regrant;
    got = 1'b0; n = 0; stb_at = 1'b1; cyc_at = 1'b1; regrant = 1'b0;
    m_req(1, 30'h33, 32'h0000_0033, 1'b0);
    sb_q.push_back('{master: 1'b1, is_err: 1'b1, dat: '0});
    tick();
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge aclk);
      if (m0_ack || m0_err || m1_ack || m1_err) begin
        got = 1'b1; n = k; stb_at = s_stb; cyc_at = s_cyc;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL timeout_resp: no expected entry queued");
        end else begin
          e = sb_q.pop_front();
          if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e)) begin
            errors++;
            $display("FAIL timeout_resp: resp got %b want %b", {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e));
          end
        end
      end
    end
    checks++;
    if (!got || n != TO) begin
      errors++;
      $display("FAIL timeout_cycle: err seen=%b at stb cycle %0d want cycle %0d", got, n, TO);
    end
    checks++;
    if ({stb_at, cyc_at} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_mask: stb/cyc got %b want 00 in err cycle", {stb_at, cyc_at});
    end
    repeat (3) begin
      @(negedge aclk);
      if (s_cyc || m1_err || m1_ack) regrant = 1'b1;
    end
    checks++;
    if (regrant !== 1'b0) begin
      errors++;
      $display("FAIL no_regrant: locked requester saw activity, got %b want 0", regrant);
    end
    tick();
    m_drop(1);
    tick();
    m_req(1, 30'h34, 32'h0000_0034, 1'b0);
    tick();
    s_ack = 1'b1; s_dat_i = 32'h0BAD_CAFE;
    sb_q.push_back('{master: 1'b1, is_err: 1'b0, dat: 32'h0BAD_CAFE});
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_adr} !== {1'b1, 30'h34}) begin
      errors++;
      $display("FAIL regrant_after_drop: got cyc=%b adr=%h want 1 34", s_cyc, s_adr);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL regrant_resp: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e) || m1_dat_o !== e.dat) begin
        errors++;
        $display("FAIL regrant_resp: resp got %b want %b", {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e));
      end
    end
    tick();
    s_ack = 1'b0; s_dat_i = '0;
    m_drop(1);
    tick();
  endtask

  task automatic test_ack_at_timeout();
    logic early;
    early = 1'b0;
    m_req(0, 30'h44, 32'h0000_0044, 1'b1);
    sb_q.push_back('{master: 1'b0, is_err: 1'b0, dat: 32'hCAFE_F00D});
    tick();
    for (int k = 1; k < TO; k++) begin
      @(negedge aclk);
      if (m0_ack || m0_err || m1_ack || m1_err || !s_stb) early = 1'b1;
      tick();
    end
    s_ack = 1'b1; s_dat_i = 32'hCAFE_F00D;
    @(negedge aclk);
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL no_early_resp: got %b want 0 before cycle %0d", early, TO);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL ack_at_limit: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e) || m0_dat_o !== e.dat || s_stb !== 1'b1) begin
        errors++;
        $display("FAIL ack_at_limit: resp got %b want %b dat %h want %h stb %b want 1",
                 {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e), m0_dat_o, e.dat, s_stb);
      end
    end
    tick();
    s_ack = 1'b0; s_dat_i = '0;
    m_drop(0);
    @(negedge aclk);
    checks++;
    if ({m0_err, m0_ack} !== 2'b00) begin
      errors++;
      $display("FAIL no_late_err: err/ack got %b want 00", {m0_err, m0_ack});
    end
    tick();
  endtask

  task automatic test_reset_midtxn();
    logic stray;
    stray = 1'b0;
    m_req(1, 30'h55, 32'h0000_0055, 1'b1);
    tick();
    tick();
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_stb} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_gnt1: cyc/stb got %b want 11", {s_cyc, s_stb});
    end
    #2;
    s_ack = 1'b1;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err} !== 6'b000000) begin
      errors++;
      $display("FAIL async_reset: got %b want 000000", {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err});
    end
    s_ack = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    m_req(0, 30'h66, 32'h0000_0066, 1'b0);
    tick();
    s_ack = 1'b1; s_dat_i = 32'h600D_0066;
    sb_q.push_back('{master: 1'b0, is_err: 1'b0, dat: 32'h600D_0066});
    @(negedge aclk);
    checks++;
    if ({s_cyc, s_adr} !== {1'b1, 30'h66}) begin
      errors++;
      $display("FAIL tie_after_reset: got cyc=%b adr=%h want 1 66", s_cyc, s_adr);
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL post_reset_resp: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if ({m1_err, m1_ack, m0_err, m0_ack} !== exp_resp(e) || m0_dat_o !== e.dat) begin
        errors++;
        $display("FAIL post_reset_resp: resp got %b want %b", {m1_err, m1_ack, m0_err, m0_ack}, exp_resp(e));
      end
    end
    tick();
    s_ack = 1'b0; s_dat_i = '0;
    m_drop(0);
    m_drop(1);
    repeat (4) begin
      @(negedge aclk);
      if (m0_ack || m0_err || m1_ack || m1_err) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_resp: stray ack/err got %b want 0", stray);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_write();
    test_tie_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_reset_midtxn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdc_wb_arbiter.md
SDC_WB_ARBITER -- requirements
Module: sdc_wb_arbiter

Interface
REQ-001 Parameter AW, default 30: word-address width of all Wishbone address buses.
REQ-002 Parameter DW, default 32: data width; select width is DW/8.
REQ-003 Parameter TIMEOUT, default 255: cycles a slave strobe may wait for ack before forced error; legal range 1..65535.
REQ-004 aclk  input  1  sole clock; all logic on rising edge.
REQ-005 aresetn  input  1  asynchronous, active-low reset.
REQ-006 m0_cyc, m0_stb, m0_we  input  1 each  requester 0 (register path) classic Wishbone controls.
REQ-007 m0_adr  input  AW; m0_dat_i  input  DW; m0_sel  input  DW/8  requester 0 address, write data and byte selects.
REQ-008 m0_ack, m0_err  output  1 each; m0_dat_o  output  DW  requester 0 responses.
REQ-009 m1_* ports  same directions and widths as m0_*  requester 1 (boot/init sequencer).
REQ-010 s_cyc, s_stb, s_we  output  1; s_adr  output  AW; s_dat_o  output  DW; s_sel  output  DW/8  shared classic slave (SD controller register port).
REQ-011 s_ack  input  1; s_dat_i  input  DW  slave responses; the slave has no error output.

Function
REQ-012 The FSM SHALL have three states: IDLE, GNT0, GNT1.
REQ-013 IDLE: a single m0_cyc or m1_cyc request SHALL move the FSM to the matching GNTn on the next edge.
REQ-014 IDLE with both cyc high: the master not granted last SHALL win; after reset the last-granted pointer SHALL point at m1, so m0 wins the first tie.
REQ-015 GNTn SHALL hold while mn_cyc stays high; no preemption.
REQ-016 GNTn with mn_cyc low SHALL return to IDLE, giving exactly one dead cycle between grants.
REQ-017 In GNTn, s_cyc/s_stb/s_we/s_adr/s_dat_o/s_sel SHALL equal mn_* combinationally (zero-cycle forward); in IDLE s_cyc and s_stb SHALL be 0.
REQ-018 s_ack SHALL be routed combinationally to mn_ack of the granted master only; the other master's ack and err SHALL be 0.
REQ-019 s_dat_i SHALL be broadcast to both m0_dat_o and m1_dat_o.
REQ-020 A 16-bit wait counter SHALL clear when s_stb is low or s_ack is high, and otherwise increment every cycle while s_stb is high.
REQ-021 When the wait counter equals TIMEOUT-1 with s_stb high and s_ack low, mn_err SHALL pulse for one cycle, s_cyc/s_stb SHALL be forced low that cycle, and the FSM SHALL go to IDLE.
REQ-022 s_ack arriving in the same cycle as the timeout condition SHALL take priority: ack delivered, no err.
REQ-023 After a timeout, the errored master SHALL NOT be re-granted until it has dropped cyc for at least one cycle.
REQ-024 A cyc drop by the granted master in the same cycle as a new request by the other master SHALL take the IDLE step first; the other master is granted on the following edge.

Reset
REQ-025 While aresetn is low: FSM = IDLE, pointer = m1, wait counter = 0, lockout flags = 0; all s_* controls and mn_ack/mn_err SHALL be 0 immediately, without waiting for a clock edge.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction; no ack or err is produced for it after reset release.

Structure
REQ-027 The state enum (IDLE, GNT0, GNT1) and the TIMEOUT default constant SHALL live in the shared sdc_pkg package.
REQ-028 The block SHALL be flat except for one sub-module, sdc_wb_timeout, which holds the wait counter and the err-pulse generation.

Verification
REQ-029 m0 single write, adr=0x0A, dat=0xDEADBEEF; slave acks on cycle 3 -> s_adr=0x0A with grant one edge after cyc, m0_ack one cycle, m1 silent.
REQ-030 m0 and m1 raise cyc on the same edge after reset -> GNT0 first; m0 drops cyc -> one IDLE cycle -> GNT1.
REQ-031 Slave never acks, TIMEOUT=8 -> m1_err pulses on the 8th stb cycle, s_stb low that cycle, FSM IDLE; m1 holding cyc is not re-granted.
REQ-032 Slave ack on exactly cycle TIMEOUT -> ack only, no err.
REQ-033 aresetn low during GNT1 with s_stb high -> all outputs 0 asynchronously; after release, m0 wins the first tie.
